// File: rtl/sram_arb_pkg.sv
// Shared defaults and arbitration helpers for the round-robin SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned DATA_W_DEF = 15;
  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DEPTH_DEF  = 32768;
  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned CH_IDX_W   = 3;

  // One-hot grant: first requester found scanning from ptr upward, modulo num_ch.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0]   req,
                                                input logic [CH_IDX_W-1:0] ptr,
                                                input int unsigned         num_ch);
    logic [MAX_CH-1:0]   gnt;
    logic                found;
    int unsigned         idx;
    logic [CH_IDX_W-1:0] sel;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (k < num_ch) begin
        idx = (32'(ptr) + k) % num_ch;
        sel = CH_IDX_W'(idx);
        if (!found && req[sel]) begin
          gnt[sel] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  function automatic logic [CH_IDX_W-1:0] onehot2idx(input logic [MAX_CH-1:0] oh);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (oh[k]) idx = idx | CH_IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Client-side bus of the round-robin SRAM arbiter; stall_cnt exists only with SRAM_ARB_STATS_EN.
interface sram_rr_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 15
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     busy;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0]              stall_cnt;

  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata,
    input  ch_gnt, ch_rvalid, rdata, busy, stall_cnt
  );
  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata,
    output ch_gnt, ch_rvalid, rdata, busy, stall_cnt
  );
`else
  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata,
    input  ch_gnt, ch_rvalid, rdata, busy
  );
  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata,
    output ch_gnt, ch_rvalid, rdata, busy
  );
`endif
endinterface

// File: rtl/sram_arb_mem.sv
// Single-port synchronous word array with registered read; out-of-range writes drop, reads give 0.
module sram_arb_mem
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              in_range;
  logic [IdxW-1:0]   idx;

  assign in_range = (64'(addr_i) < 64'(DEPTH));
  assign idx      = addr_i[IdxW-1:0];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i && in_range) begin
      mem_q[idx] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = in_range ? mem_q[idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_rr_arbiter.sv
// N-channel round-robin arbiter in front of a shared SRAM, one access per cycle.
// Optional stall counter port enabled by defining SRAM_ARB_STATS_EN.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned NUM_CH = 2
) (
  input logic                clk,
  input logic                rst,
  sram_rr_arbiter_if.slave   bus
);

  logic [CH_IDX_W-1:0] ptr_d, ptr_q;
  logic [NUM_CH-1:0]   rvalid_d, rvalid_q;
  logic                busy_d, busy_q;
  logic [MAX_CH-1:0]   req_ext;
  logic [MAX_CH-1:0]   pick_full;
  logic [MAX_CH-1:0]   gnt_full;
  logic [NUM_CH-1:0]   gnt;
  logic [CH_IDX_W-1:0] g_idx;
  logic                any_gnt;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_CH-1:0]  = bus.ch_req;
    pick_full            = rr_pick(req_ext, ptr_q, NUM_CH);
    // Reset suppresses grants so nothing is written while rst is high.
    gnt_full             = rst ? '0 : pick_full;
    gnt                  = gnt_full[NUM_CH-1:0];
    g_idx                = onehot2idx(gnt_full);
    any_gnt              = |gnt;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_we    = bus.ch_we[i];
        sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    if (any_gnt) begin
      ptr_d = CH_IDX_W'((32'(g_idx) + 1) % NUM_CH);
    end
    rvalid_d = gnt & ~bus.ch_we;
    busy_d   = |bus.ch_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
    end
  end

  sram_arb_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (any_gnt),
    .we_i    (sel_we),
    .addr_i  (sel_addr),
    .wdata_i (sel_wdata),
    .rdata_o (bus.rdata)
  );

  assign bus.ch_gnt    = gnt;
  // A read landing on the reset edge must not be reported.
  assign bus.ch_rvalid = rst ? '0 : rvalid_q;
  assign bus.busy      = busy_q;

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [3:0]  n_stall;
  logic [32:0] stall_sum;

  always_comb begin
    n_stall = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      n_stall = n_stall + {3'b000, bus.ch_req[i] & ~gnt[i]};
    end
    stall_sum   = {1'b0, stall_cnt_q} + 33'(n_stall);
    stall_cnt_d = stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
